// File: rtl/rgb_pkg.sv
// Shared types and constants for the serial RGB frame decoder.
package rgb_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  localparam int CHAN_W  = 8;
  localparam int FRAME_W = 3 * CHAN_W;

endpackage

// File: rtl/rgb_shift_rx.sv
// Serial frame capture: MSB-first shift register, bit counter and idle timer.
// frame_done/timeout are combinational strobes qualified by en (FSM in SHIFT).
module rgb_shift_rx #(
  parameter int FRM_W   = 24,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             sdata_in,
  input  logic             sdata_valid,
  output logic [FRM_W-1:0] shreg,
  output logic             frame_done,
  output logic             timeout
);

  localparam int CW = $clog2(FRM_W);
  localparam int TW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;
  logic [TW-1:0] idle;

  // clear (frame_start) wins over any bit presented in the same cycle
  assign frame_done = en && !clear && sdata_valid && (cnt == CW'(FRM_W - 1));
  assign timeout    = en && !clear && !sdata_valid && (idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      idle  <= '0;
    end else if (clear) begin
      cnt  <= '0;
      idle <= '0;
    end else if (en) begin
      if (sdata_valid) begin
        shreg <= {shreg[FRM_W-2:0], sdata_in};
        cnt   <= frame_done ? '0 : cnt + 1'b1;
        idle  <= '0;
      end else begin
        idle  <= timeout ? '0 : idle + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_colour_decoder.sv
// Recovers a 3-bit colour code from a serial R,G,B frame with a valid/ready output.
// THRESHOLD_DECODE_EN: channel on = MSB set, no invalid-value error.
module rgb_colour_decoder
  import rgb_pkg::*;
#(
  parameter int CHAN_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       sdata_in,
  input  logic       sdata_valid,
  output logic [2:0] colour_out,
  output logic       colour_valid,
  input  logic       colour_ready,
  output logic       err,
  output logic       overrun
);

  localparam int FRM_W = 3 * CHAN_W;

  state_t             state, state_nx;
  logic [FRM_W-1:0]   shreg;
  logic               frame_done, timeout;
  logic [2:0]         code_nx, dec_code;
  logic               bad_nx, dec_vld;
  logic [CHAN_W-1:0]  ch;

  rgb_shift_rx #(.FRM_W(FRM_W), .TIMEOUT(TIMEOUT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .clear       (frame_start),
    .en          (state == SHIFT),
    .sdata_in    (sdata_in),
    .sdata_valid (sdata_valid),
    .shreg       (shreg),
    .frame_done  (frame_done),
    .timeout     (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = SHIFT;
      SHIFT:   if (frame_start)     state_nx = SHIFT;
               else if (frame_done) state_nx = DECODE;
               else if (timeout)    state_nx = IDLE;
      DECODE:  state_nx = frame_start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // channel c=0 is the last byte received (B), so it maps to colour[0]
  always_comb begin
    code_nx = '0;
    bad_nx  = 1'b0;
    ch      = '0;
    for (int c = 0; c < 3; c++) begin
      ch = shreg[c*CHAN_W +: CHAN_W];
`ifdef THRESHOLD_DECODE_EN
      code_nx[c] = ch[CHAN_W-1];
`else
      code_nx[c] = &ch;
      if ((|ch) && !(&ch)) bad_nx = 1'b1;
`endif
    end
  end

  // decode stage: registered one edge after the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_vld  <= 1'b0;
      dec_code <= '0;
      err      <= 1'b0;
    end else begin
      dec_vld  <= (state == DECODE) && !bad_nx;
      dec_code <= code_nx;
      err      <= (state == SHIFT && timeout) || (state == DECODE && bad_nx);
    end
  end

  // output holding register; a new code while one is stalled is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_out   <= BLACK;
      colour_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (dec_vld) begin
      if (!colour_valid || colour_ready) begin
        colour_out   <= dec_code;
        colour_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (colour_valid && colour_ready) begin
      colour_valid <= 1'b0;
    end
  end

endmodule
